// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-to-parallel receive path.
package sipo_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } sipo_state_e;

  // Bits needed to hold any value in 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sipo_out_stage.sv
// One-word holding register on the parallel side; flags a completed word that
// arrives while the held word has not been taken (overrun).
module sipo_out_stage
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overrun
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overrun;
  logic             w_free;

  // Valid/ready: a word moves when o_valid and i_ready are both 1 at a rising
  // edge; while o_valid=1 and i_ready=0, o_data and o_valid hold still.
  assign w_free = !r_valid || i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (i_load) begin
        if (w_free) begin
          r_data  <= i_data;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/sipo_deserializer.sv
// Framed serial-to-parallel receiver with sof alignment and holding buffer.
// Define SIPO_PARITY_EN to append and check a trailing even-parity bit per frame.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  output logic             frame_err,
`ifdef SIPO_PARITY_EN
  output logic             parity_err,
`endif
  output logic [1:0]       o_dbg_state
);

  localparam int                CNT_W    = clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH);

  sipo_state_e      r_state;
  sipo_state_e      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_word;
  logic             w_load;
  logic             w_frame_err;
  logic             r_frame_err;
  logic             w_parity_err;
`ifdef SIPO_PARITY_EN
  logic             r_parity_err;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= HUNT;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
`ifdef SIPO_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_frame_err <= w_frame_err;
`ifdef SIPO_PARITY_EN
      r_parity_err <= w_parity_err;
`endif
    end
  end

  always_comb begin
    // A sof bit restarts assembly from an empty register, dropping any partial word.
    w_base = sof ? '0 : r_shift;
    if (MSB_FIRST) w_shifted = {w_base[WIDTH-2:0], sin};
    else           w_shifted = {sin, w_base[WIDTH-1:1]};
    w_cnt_inc = (sof ? '0 : r_cnt) + CNT_W'(1);

    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_shift_nxt  = r_shift;
    w_word       = w_shifted;
    w_load       = 1'b0;
    w_frame_err  = 1'b0;
    w_parity_err = 1'b0;

    if (sin_valid) begin
      w_frame_err = sof && (r_state != HUNT);
      if (sof || r_state == SHIFT) begin
        w_shift_nxt = w_shifted;
        w_cnt_nxt   = w_cnt_inc;
        w_state_nxt = SHIFT;
        if (w_cnt_inc == LAST_CNT) begin
`ifdef SIPO_PARITY_EN
          w_state_nxt = PARITY;
`else
          w_state_nxt = HUNT;
          w_cnt_nxt   = '0;
          w_load      = 1'b1;
`endif
        end
      end
`ifdef SIPO_PARITY_EN
      else if (r_state == PARITY) begin
        w_state_nxt = HUNT;
        w_cnt_nxt   = '0;
        w_word      = r_shift;
        if ((^r_shift) == sin) w_load = 1'b1;
        else                   w_parity_err = 1'b1;
      end
`endif
    end
  end

  sipo_out_stage #(
    .WIDTH (WIDTH)
  ) u_out_stage (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .i_load    (w_load),
    .i_data    (w_word),
    .i_ready   (dout_ready),
    .o_data    (dout),
    .o_valid   (dout_valid),
    .o_overrun (overrun)
  );

  assign frame_err   = r_frame_err;
  assign o_dbg_state = r_state;
`ifdef SIPO_PARITY_EN
  assign parity_err  = r_parity_err;
`else
  logic w_unused;
  assign w_unused = w_parity_err;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: MSB-first and LSB-first instances share one
// stimulus stream and are checked against a frame-level reference model.
module tb_sipo_deserializer;

  localparam int W = 4;
`ifdef SIPO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME_LEN = W + PAR;

  logic clk;
  logic rst;
  logic sin, sin_valid, sof, dout_ready;
  logic [W-1:0] dout_m, dout_l;
  logic valid_m, valid_l, ovr_m, ovr_l, fe_m, fe_l;
  logic [1:0] dbg_m, dbg_l;
`ifdef SIPO_PARITY_EN
  logic perr_m, perr_l;
`endif

  int n_cmp;
  int n_err;

  // reference model state
  bit f_q[$];
  bit in_frame;
  logic exp_valid;
  logic [W-1:0] exp_m, exp_l;
  logic exp_ovr, exp_fe, exp_perr;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .dout(dout_m), .dout_valid(valid_m), .dout_ready(dout_ready),
    .overrun(ovr_m), .frame_err(fe_m),
`ifdef SIPO_PARITY_EN
    .parity_err(perr_m),
`endif
    .o_dbg_state(dbg_m)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .dout(dout_l), .dout_valid(valid_l), .dout_ready(dout_ready),
    .overrun(ovr_l), .frame_err(fe_l),
`ifdef SIPO_PARITY_EN
    .parity_err(perr_l),
`endif
    .o_dbg_state(dbg_l)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    f_q.delete();
    in_frame  = 1'b0;
    exp_valid = 1'b0;
    exp_m     = '0;
    exp_l     = '0;
    exp_ovr   = 1'b0;
    exp_fe    = 1'b0;
    exp_perr  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; sin = 1'b0; sin_valid = 1'b0; sof = 1'b0; dout_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // driver: apply one cycle of inputs, advance the model, sample 1 ns after the edge
  task automatic drive(input logic b, input logic v, input logic s, input logic r);
    logic [W-1:0] wm, wl;
    bit done, good, par;
    sin = b; sin_valid = v; sof = s; dout_ready = r;
    exp_ovr = 1'b0; exp_fe = 1'b0; exp_perr = 1'b0;
    done = 1'b0; good = 1'b0; par = 1'b0; wm = '0; wl = '0;
    if (v) begin
      if (s) begin
        exp_fe = in_frame;
        f_q.delete();
        in_frame = 1'b1;
      end
      if (in_frame) f_q.push_back(b);
      if (in_frame && f_q.size() == FRAME_LEN) begin
        done = 1'b1;
        in_frame = 1'b0;
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = f_q[i];
          wl[i]     = f_q[i];
          par       = par ^ f_q[i];
        end
        good = (PAR == 0) || (par == f_q[FRAME_LEN-1]);
        exp_perr = !good;
        f_q.delete();
      end
    end
    if (done && good) begin
      if (!exp_valid || r) begin
        exp_valid = 1'b1;
        exp_m = wm;
        exp_l = wl;
      end else begin
        exp_ovr = 1'b1;
      end
    end else if (exp_valid && r) begin
      exp_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // first bit of the frame is w[W-1]; appends the even-parity bit when enabled
  task automatic send_frame(input logic [W-1:0] w, input logic r);
    for (int i = 0; i < W; i++) drive(w[W-1-i], 1'b1, i == 0, r);
    if (PAR != 0) drive(^w, 1'b1, 1'b0, r);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (valid_m !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", valid_m); end
    n_cmp++; if (dout_m !== 4'b0000) begin n_err++; $display("FAIL reset_dout_m got=%b want=0000", dout_m); end
    n_cmp++; if (dout_l !== 4'b0000) begin n_err++; $display("FAIL reset_dout_l got=%b want=0000", dout_l); end
    n_cmp++; if ({ovr_m, fe_m, ovr_l, fe_l} !== 4'b0000) begin n_err++; $display("FAIL reset_flags got=%b want=0000", {ovr_m, fe_m, ovr_l, fe_l}); end
  endtask

  task automatic test_single_word();
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (valid_m !== 1'b0) begin n_err++; $display("FAIL early_valid got=%b want=0", valid_m); end
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    if (PAR != 0) drive(1'b1, 1'b1, 1'b0, 1'b1);
    n_cmp++; if ({valid_m, valid_l} !== 2'b11) begin n_err++; $display("FAIL word_valid got=%b want=11", {valid_m, valid_l}); end
    n_cmp++; if (dout_m !== 4'b1011) begin n_err++; $display("FAIL word_msb got=%b want=1011", dout_m); end
    n_cmp++; if (dout_l !== 4'b1101) begin n_err++; $display("FAIL word_lsb got=%b want=1101", dout_l); end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (valid_m !== 1'b0) begin n_err++; $display("FAIL valid_one_cycle got=%b want=0", valid_m); end
    n_cmp++; if (dout_m !== 4'b1011) begin n_err++; $display("FAIL dout_kept got=%b want=1011", dout_m); end
  endtask

  task automatic test_overrun();
    do_reset();
    send_frame(4'b1011, 1'b0);
    n_cmp++; if (valid_m !== 1'b1 || dout_m !== 4'b1011) begin n_err++; $display("FAIL hold_first got=%b/%b want=1/1011", valid_m, dout_m); end
    for (int i = 0; i < W; i++) drive(i == 1 || i == 2, 1'b1, i == 0, 1'b0);
    if (PAR != 0) drive(1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if ({ovr_m, ovr_l} !== 2'b11) begin n_err++; $display("FAIL overrun_pulse got=%b want=11", {ovr_m, ovr_l}); end
    n_cmp++; if (dout_m !== 4'b1011 || dout_l !== 4'b1101) begin n_err++; $display("FAIL overrun_hold got=%b/%b want=1011/1101", dout_m, dout_l); end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (ovr_m !== 1'b0) begin n_err++; $display("FAIL overrun_clear got=%b want=0", ovr_m); end
    n_cmp++; if (valid_m !== 1'b0) begin n_err++; $display("FAIL drain_valid got=%b want=0", valid_m); end
  endtask

  task automatic test_frame_err();
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    n_cmp++; if ({fe_m, fe_l} !== 2'b11) begin n_err++; $display("FAIL frame_err_pulse got=%b want=11", {fe_m, fe_l}); end
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (fe_m !== 1'b0) begin n_err++; $display("FAIL frame_err_clear got=%b want=0", fe_m); end
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    if (PAR != 0) drive(1'b1, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (valid_m !== 1'b1 || dout_m !== 4'b0111) begin n_err++; $display("FAIL realign_msb got=%b/%b want=1/0111", valid_m, dout_m); end
    n_cmp++; if (dout_l !== 4'b1110) begin n_err++; $display("FAIL realign_lsb got=%b want=1110", dout_l); end
  endtask

  task automatic test_async_reset();
    do_reset();
    send_frame(4'b1011, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b0;
    model_clear();
    #1;
    n_cmp++; if ({valid_m, valid_l} !== 2'b00) begin n_err++; $display("FAIL async_valid got=%b want=00", {valid_m, valid_l}); end
    n_cmp++; if (dout_m !== 4'b0000 || dout_l !== 4'b0000) begin n_err++; $display("FAIL async_dout got=%b/%b want=0000/0000", dout_m, dout_l); end
    @(posedge clk);
    #1 rst = 1'b1;
    send_frame(4'b1001, 1'b1);
    n_cmp++; if (valid_m !== 1'b1 || dout_m !== 4'b1001 || dout_l !== 4'b1001) begin n_err++; $display("FAIL after_reset got=%b/%b/%b want=1/1001/1001", valid_m, dout_m, dout_l); end
  endtask

`ifdef SIPO_PARITY_EN
  task automatic test_parity();
    do_reset();
    for (int i = 0; i < W; i++) drive(i != 1, 1'b1, i == 0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (valid_m !== 1'b1 || dout_m !== 4'b1011 || perr_m !== 1'b0) begin n_err++; $display("FAIL parity_ok got=%b/%b/%b want=1/1011/0", valid_m, dout_m, perr_m); end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < W; i++) drive(i != 1, 1'b1, i == 0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    n_cmp++; if ({perr_m, perr_l} !== 2'b11) begin n_err++; $display("FAIL parity_err_pulse got=%b want=11", {perr_m, perr_l}); end
    n_cmp++; if (valid_m !== 1'b0) begin n_err++; $display("FAIL parity_drop got=%b want=0", valid_m); end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (perr_m !== 1'b0) begin n_err++; $display("FAIL parity_err_clear got=%b want=0", perr_m); end
  endtask
`endif

  // scoreboard run: random bits, strobes, sof and back-pressure against the model
  task automatic test_random();
    logic b, v, s, r;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      v = ($urandom_range(0, 9) < 7);
      b = 1'($urandom_range(0, 1));
      s = v && ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 9) < 6);
      drive(b, v, s, r);
      n_cmp++; if (valid_m !== exp_valid || valid_l !== exp_valid) begin n_err++; $display("FAIL rnd_valid c=%0d got=%b/%b want=%b", c, valid_m, valid_l, exp_valid); end
      n_cmp++; if (dout_m !== exp_m) begin n_err++; $display("FAIL rnd_dout_msb c=%0d got=%b want=%b", c, dout_m, exp_m); end
      n_cmp++; if (dout_l !== exp_l) begin n_err++; $display("FAIL rnd_dout_lsb c=%0d got=%b want=%b", c, dout_l, exp_l); end
      n_cmp++; if (ovr_m !== exp_ovr || ovr_l !== exp_ovr) begin n_err++; $display("FAIL rnd_overrun c=%0d got=%b/%b want=%b", c, ovr_m, ovr_l, exp_ovr); end
      n_cmp++; if (fe_m !== exp_fe || fe_l !== exp_fe) begin n_err++; $display("FAIL rnd_frame_err c=%0d got=%b/%b want=%b", c, fe_m, fe_l, exp_fe); end
`ifdef SIPO_PARITY_EN
      n_cmp++; if (perr_m !== exp_perr || perr_l !== exp_perr) begin n_err++; $display("FAIL rnd_parity_err c=%0d got=%b/%b want=%b", c, perr_m, perr_l, exp_perr); end
`endif
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single_word();
    test_overrun();
    test_frame_err();
    test_async_reset();
`ifdef SIPO_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Receive end of the team's serial bit-stream link: collects a framed serial bit stream into WIDTH-bit parallel words.
- Presents each word on a valid/ready output port.
- Sits downstream of the serial shifting path and feeds parallel consumers (register files, FIFOs).
- Adds frame alignment via start-of-frame, overrun detection and a one-word holding buffer.

Parameters:
- WIDTH, 4, data bits per word (legal values 2 to 32).
- MSB_FIRST, 1, 1: first received bit lands in dout[WIDTH-1]; 0: first bit lands in dout[0].

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- sin  input  1  serial data bit.
- sin_valid  input  1  bit strobe; sin is sampled only when 1.
- sof  input  1  start-of-frame; qualified by sin_valid; marks the current bit as bit 0 of a new word.
- dout  output  WIDTH  assembled word held for the consumer.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts; a transfer occurs when dout_valid and dout_ready are both 1.
- overrun  output  1  one-cycle pulse: a completed word was dropped.
- frame_err  output  1  one-cycle pulse: sof arrived mid-word.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=HUNT, bit counter=0, shift register=0.
  - dout=0, dout_valid=0, overrun=0, frame_err=0.
  - Reset mid-word discards the partial word and any held word.
- HUNT state:
  - Bits with sin_valid=1 and sof=0 are ignored.
  - sin_valid=1 and sof=1: bit captured as bit 0, cnt=1, go to SHIFT.
  - If WIDTH bits are already complete at that point (no parity), apply the completion rule instead.
- SHIFT state:
  - Each sin_valid=1 shifts sin into the shift register and increments cnt.
  - The bit with cnt==WIDTH-1 completes the word; return to HUNT.
- Bit order:
  - MSB_FIRST=1: shift_reg <= {shift_reg[WIDTH-2:0], sin}.
  - MSB_FIRST=0: shift_reg <= {sin, shift_reg[WIDTH-1:1]}.
- sof in SHIFT:
  - Partial word is discarded and frame_err pulses for one cycle.
  - The sof bit becomes bit 0 of the new word (cnt=1); state stays SHIFT.
- Completion rule, evaluated at the edge that samples the last bit:
  - Holding buffer free (dout_valid=0, or dout_valid=1 and dout_ready=1 in the same cycle): dout loads the completed word; dout_valid=1 from the next cycle.
  - Latency is therefore 1 cycle from the last-bit edge to dout_valid.
  - Holding buffer busy (dout_valid=1, dout_ready=0): the new word is dropped, the held word is unchanged, and overrun pulses for one cycle.
- Output handshake:
  - dout and dout_valid are stable while dout_valid=1 and dout_ready=0.
  - A transfer with no new completion clears dout_valid next cycle.
  - dout keeps its last value after the transfer.
- sin_valid=0 cycles:
  - No change to the shift register, cnt or state.
  - Gaps of any length between bits are legal.
- All outputs are registered.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- Defined:
  - Each frame carries WIDTH data bits plus one trailing even-parity bit.
  - After the last data bit the FSM enters PARITY; the next sin_valid bit is checked against the XOR of the data bits.
  - Output port parity_err (1 bit) is added; it pulses for one cycle on mismatch, and the word is dropped (not loaded).
  - On match, the word is loaded per the completion rule at the parity-bit edge.
  - sof during PARITY is handled as in SHIFT (frame_err, restart).
- Undefined:
  - No PARITY state and no parity_err port.
  - Frames are exactly WIDTH bits.

Decomposition:
- Package sipo_pkg holds:
  - state enum HUNT/SHIFT/PARITY (2-bit encoding).
  - Counter width function clog2(WIDTH+1).
  - Default WIDTH constant.
- Sub-module sipo_out_stage holds the one-word valid/ready holding register and overrun generation.
- The FSM, counter and shift register stay in the top module.

Test Plan:
- WIDTH=4, MSB_FIRST=1, bits 1,0,1,1 with sof on the first bit, dout_ready=1 -> dout=4'b1011, dout_valid=1 for exactly one cycle, starting one cycle after the 4th bit.
- Same stream with MSB_FIRST=0 -> dout=4'b1101.
- Words 1011 then 0110 back-to-back with dout_ready=0 -> dout stays 1011; overrun pulses once at the last bit of 0110; after dout_ready=1, dout_valid drops.
- 2 bits of a word, then sof with bits 0,1,1,1 -> frame_err pulses once; dout=4'b0111.
- rst=0 asserted after bit 2, with dout holding a word -> dout_valid=0 and dout=0 immediately (asynchronous); the next sof-framed word 1001 is received correctly.
- With SIPO_PARITY_EN: data 1011 with parity 1 -> dout=1011; data 1011 with parity 0 -> parity_err pulse, dout_valid stays 0.
